csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the CSR file's access port: executes one Zicsr instruction (CSRRW/CSRRS/CSRRC and the immediate forms) by sequencing a read, a read-modify-write computation and a write.
- Sits between the decode/execute stage and the CSR file.
- Returns the old CSR value for write-back to rd.
- Flags illegal accesses to the trap logic.

Parameters:
- XLEN, 32, data width of CSRs and register file.
- READ_LATENCY, 1, cycles from csr_re/csr_addr being valid to csr_rdata being valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous reset, active-high; resetn=1 clears all state immediately.
- start  in  1  request strobe; sampled only while busy=0.
- funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr_in  in  12  target CSR address.
- rs1_data  in  XLEN  source operand for register forms.
- rs1_idx  in  5  rs1 field; used as the zero-extended immediate (zimm) in the I forms.
- rd_idx  in  5  destination register index.
- csr_addr  out  12  address to CSR file.
- csr_re  out  1  read strobe to CSR file.
- csr_we  out  1  one-cycle write strobe to CSR file.
- csr_wdata  out  XLEN  write data.
- csr_rdata  in  XLEN  CSR file read bus.
- rd_we  out  1  one-cycle register-file write strobe; never asserted when rd_idx=0.
- rd_addr  out  5  write-back index.
- rd_data  out  XLEN  old CSR value.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  valid only with done; high means the access was rejected.

Behaviour:
- Reset values: state IDLE; all outputs 0, including csr_addr, csr_wdata, rd_addr, rd_data and the internal operand/old-value registers.
- Acceptance: start is ignored while busy=1. On acceptance in IDLE, latch:
  - funct3, csr_addr_in and rd_idx;
  - the operand: rs1_data for funct3[2]=0, else {27'b0, rs1_idx}.
  - Drive csr_addr from the latch until done.
- Derived flags:
  - do_read = !(funct3[1:0]==01 && rd_idx==0).
  - do_write = (funct3[1:0]==01) || (src_idx != 0). Here src_idx = rs1_idx; for RS/RC the flag depends on the index, not the data value.
  - ro = csr_addr_in[11:10]==2'b11.
- Illegal cases:
  - funct3 in {000, 100}, or do_write && ro.
  - Next state is DONE with illegal=1.
  - No csr_re, csr_we or rd_we is asserted.
  - done falls at cycle T+1, where T is the accept edge.
- States and transitions:
  - IDLE -> RD if do_read, else WR.
  - RD: csr_re=1 for exactly READ_LATENCY cycles using an internal down-counter. On the last of these cycles, capture csr_rdata into old_val. Then -> WR if do_write, else DONE.
  - WR: csr_we=1 for one cycle. csr_wdata is selected by funct3[1:0]:
    - 01: operand.
    - 10: old_val | operand.
    - 11: old_val & ~operand.
    - Then -> DONE.
  - DONE: done=1 and illegal as computed. rd_we = do_read && rd_idx!=0 && !illegal; rd_data=old_val; rd_addr=rd_idx. busy=0 in DONE. Then -> IDLE.
- Back-to-back: a start presented during DONE is not accepted; the next request is accepted in IDLE, one cycle later.
- Latency from the accept edge to done high:
  - RW with rd=0: 2 cycles.
  - Read only: READ_LATENCY+1.
  - Read and write: READ_LATENCY+2.
- The write in a WR state always completes before rd_we. A CSR whose value changes between the read and the write is not re-read; the unit is atomic only with respect to itself.
- Reset asserted mid-operation: all strobes drop asynchronously. No partial write is issued after reset deasserts.

Optional Feature:
- Macro CSR_ACCESS_PERF_EN.
- When defined, adds output perf_count (XLEN), reset 0. It increments on every done with illegal=0 and wraps from 2^XLEN-1 to 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- CSRRW with old=0x00000008, rs1_data=0x00001888, rd=5, READ_LATENCY=1:
  - csr_re for 1 cycle, then csr_we with csr_wdata=0x00001888.
  - done at T+3 with rd_we=1, rd_addr=5, rd_data=0x00000008.
- CSRRS with old=0x000000F0, rs1_data=0x0000000F, rs1=3 -> csr_wdata=0x000000FF. CSRRC with the same operands -> csr_wdata=0x000000F0.
- CSRRSI with zimm=0 on address 0xF11 -> read only, no csr_we, illegal=0, done at T+2.
- CSRRW to 0xC00, or funct3=100 -> done at T+1 with illegal=1; csr_re, csr_we and rd_we never assert.
- CSRRWI with rd=0 and zimm=0x1F -> no csr_re, csr_wdata=0x0000001F, rd_we=0, done at T+2.
- Reset asserted while csr_re=1 -> busy, csr_re and csr_we go to 0 immediately. After release, start is accepted normally. With CSR_ACCESS_PERF_EN, perf_count counts only non-illegal completions.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - CSR file access bus between the access unit and the CSR file
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_addr;
    logic            csr_re;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport master (
        output csr_addr, csr_re, csr_we, csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_addr, csr_re, csr_we, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr read/modify/write sequencer toward the CSR file
// Optional macro CSR_ACCESS_PERF_EN adds perf_count (legal completions).
module csr_access_unit #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [11:0]       csr_addr_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [4:0]        rs1_idx,
    input  logic [4:0]        rd_idx,
    csr_access_unit_if.master csr,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic              busy,
    output logic              done,
`ifdef CSR_ACCESS_PERF_EN
    output logic [XLEN-1:0]   perf_count,
`endif
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] RD_LOAD = 2'(READ_LATENCY - 1);

    state_t          state_q, state_d;
    logic [1:0]      f3_q, f3_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] operand_q, operand_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            do_read_q, do_read_d;
    logic            do_write_q, do_write_d;
    logic            illegal_q, illegal_d;

    logic            acc_read, acc_write, acc_ill;
    logic [XLEN-1:0] wdata;

    // Flags are derived from the raw request inputs so they can steer the first transition.
    always_comb begin
        acc_read  = !(funct3[1:0] == 2'b01 && rd_idx == 5'd0);
        acc_write = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        acc_ill   = (funct3[1:0] == 2'b00) || (acc_write && csr_addr_in[11:10] == 2'b11);
    end

    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        operand_d  = operand_q;
        old_d      = old_q;
        cnt_d      = cnt_q;
        do_read_d  = do_read_q;
        do_write_d = do_write_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d       = funct3[1:0];
                    addr_d     = csr_addr_in;
                    rd_d       = rd_idx;
                    operand_d  = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
                    do_read_d  = acc_read;
                    do_write_d = acc_write;
                    illegal_d  = acc_ill;
                    cnt_d      = RD_LOAD;
                    if (acc_ill)       state_d = S_DONE;
                    else if (acc_read) state_d = S_RD;
                    else               state_d = S_WR;
                end
            end
            S_RD: begin
                if (cnt_q == 2'd0) begin
                    old_d   = csr.csr_rdata;
                    state_d = do_write_q ? S_WR : S_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (f3_q)
            2'b10:   wdata = old_q | operand_q;
            2'b11:   wdata = old_q & ~operand_q;
            default: wdata = operand_q;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            f3_q       <= 2'b00;
            addr_q     <= 12'h000;
            rd_q       <= 5'd0;
            operand_q  <= '0;
            old_q      <= '0;
            cnt_q      <= 2'd0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            operand_q  <= operand_d;
            old_q      <= old_d;
            cnt_q      <= cnt_d;
            do_read_q  <= do_read_d;
            do_write_q <= do_write_d;
            illegal_q  <= illegal_d;
        end
    end

    // Strobes decode straight from the state so an asynchronous reset drops them at once.
    always_comb begin
        csr.csr_addr  = addr_q;
        csr.csr_re    = (state_q == S_RD);
        csr.csr_we    = (state_q == S_WR);
        csr.csr_wdata = (state_q == S_WR) ? wdata : '0;
        busy          = (state_q == S_RD) || (state_q == S_WR);
        done          = (state_q == S_DONE);
        illegal       = (state_q == S_DONE) && illegal_q;
        rd_we         = (state_q == S_DONE) && do_read_q && (rd_q != 5'd0) && !illegal_q;
        rd_addr       = rd_q;
        rd_data       = old_q;
    end

`ifdef CSR_ACCESS_PERF_EN
    logic [XLEN-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_DONE && !illegal_q) perf_d = perf_q + 1'b1;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - directed self-checking bench for csr_access_unit
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr_in;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_idx;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        illegal;
`ifdef CSR_ACCESS_PERF_EN
    logic [31:0] perf_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_perf = 0;

    csr_access_unit_if #(.XLEN(32)) bus ();

    csr_access_unit #(.XLEN(32), .READ_LATENCY(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .funct3      (funct3),
        .csr_addr_in (csr_addr_in),
        .rs1_data    (rs1_data),
        .rs1_idx     (rs1_idx),
        .rd_idx      (rd_idx),
        .csr         (bus.master),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
`ifdef CSR_ACCESS_PERF_EN
        .perf_count  (perf_count),
`endif
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] d, input logic [4:0] ri, input logic [4:0] rd,
                       input logic [31:0] old, input int e_lat, input int e_re, input int e_we,
                       input logic [31:0] e_wd, input int e_rdwe, input logic [31:0] e_rdd,
                       input logic e_ill);
        int lat, re_n, we_n, rdwe_n;
        logic [31:0] wd;
        logic seen;
        lat = 0; re_n = 0; we_n = 0; rdwe_n = 0; wd = 32'h0; seen = 1'b0;
        @(negedge clk);
        funct3 = f3; csr_addr_in = a; rs1_data = d; rs1_idx = ri; rd_idx = rd;
        bus.csr_rdata = old;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.csr_re) re_n++;
            if (bus.csr_we) begin
                we_n++;
                wd = bus.csr_wdata;
                chk({tag, "_waddr"}, {20'h0, bus.csr_addr}, {20'h0, a});
            end
            if (rd_we) rdwe_n++;
            if (done) begin
                seen = 1'b1;
                chk({tag, "_illegal"}, {31'h0, illegal}, {31'h0, e_ill});
                chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
                if (e_rdwe != 0) begin
                    chk({tag, "_rd_addr"}, {27'h0, rd_addr}, {27'h0, rd});
                    chk({tag, "_rd_data"}, rd_data, e_rdd);
                end
            end
        end
        chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_re_cycles"}, re_n, e_re);
        chk({tag, "_we_cycles"}, we_n, e_we);
        chk({tag, "_wdata"}, wd, e_wd);
        chk({tag, "_rd_we"}, rdwe_n, e_rdwe);
        if (!e_ill) exp_perf++;
    endtask

    initial begin
        int we_n;
        resetn = 1'b0; start = 1'b0; funct3 = 3'b0; csr_addr_in = 12'h0;
        rs1_data = 32'h0; rs1_idx = 5'd0; rd_idx = 5'd0; bus.csr_rdata = 32'h0;
        #2 resetn = 1'b1;
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_re", {31'h0, bus.csr_re}, 32'h0);
        chk("rst_we", {31'h0, bus.csr_we}, 32'h0);
        chk("rst_rd_we", {31'h0, rd_we}, 32'h0);
        chk("rst_csr_addr", {20'h0, bus.csr_addr}, 32'h0);
        chk("rst_wdata", bus.csr_wdata, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_addr", {27'h0, rd_addr}, 32'h0);
        chk("rst_illegal", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;

        //   tag       f3      addr    rs1_data      rs1  rd  old           lat re we wdata         rdwe rd_data       ill
        run("rw",    3'b001, 12'h300, 32'h00001888, 5'd1, 5'd5, 32'h00000008, 3, 1, 1, 32'h00001888, 1, 32'h00000008, 1'b0);
        run("rs",    3'b010, 12'h300, 32'h0000000F, 5'd3, 5'd6, 32'h000000F0, 3, 1, 1, 32'h000000FF, 1, 32'h000000F0, 1'b0);
        run("rc",    3'b011, 12'h300, 32'h0000000F, 5'd3, 5'd6, 32'h000000F0, 3, 1, 1, 32'h000000F0, 1, 32'h000000F0, 1'b0);
        run("rsi0",  3'b110, 12'hF11, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h00001234, 2, 1, 0, 32'h00000000, 1, 32'h00001234, 1'b0);
        run("rw_ro", 3'b001, 12'hC00, 32'h00000055, 5'd2, 5'd5, 32'h00000077, 1, 0, 0, 32'h00000000, 0, 32'h00000000, 1'b1);
        run("f100",  3'b100, 12'h300, 32'h00000055, 5'd2, 5'd5, 32'h00000077, 1, 0, 0, 32'h00000000, 0, 32'h00000000, 1'b1);
        run("f000",  3'b000, 12'h300, 32'h00000055, 5'd2, 5'd5, 32'h00000077, 1, 0, 0, 32'h00000000, 0, 32'h00000000, 1'b1);
        run("rwi_r0",3'b101, 12'h340, 32'hDEADBEEF, 5'h1F, 5'd0, 32'h00000099, 2, 0, 1, 32'h0000001F, 0, 32'h00000000, 1'b0);
        run("rs_ro", 3'b010, 12'hC00, 32'hFFFFFFFF, 5'd0, 5'd3, 32'h0000ABCD, 2, 1, 0, 32'h00000000, 1, 32'h0000ABCD, 1'b0);
        run("rc_d0", 3'b011, 12'h305, 32'h00000000, 5'd9, 5'd4, 32'hA5A5A5A5, 3, 1, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1'b0);
        run("rsi_r0",3'b110, 12'h300, 32'h00000000, 5'd4, 5'd0, 32'h00000100, 3, 1, 1, 32'h00000104, 0, 32'h00000000, 1'b0);
        run("rci",   3'b111, 12'h300, 32'h00000000, 5'd5, 5'd8, 32'h000000FF, 3, 1, 1, 32'h000000FA, 1, 32'h000000FF, 1'b0);

`ifdef CSR_ACCESS_PERF_EN
        @(negedge clk);
        chk("perf_before_reset", perf_count, exp_perf);
`endif

        @(negedge clk);
        funct3 = 3'b001; csr_addr_in = 12'h300; rs1_data = 32'h12345678;
        rs1_idx = 5'd1; rd_idx = 5'd2; bus.csr_rdata = 32'h1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mid_re_before_reset", {31'h0, bus.csr_re}, 32'h1);
        chk("mid_busy_before_reset", {31'h0, busy}, 32'h1);
        resetn = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_re", {31'h0, bus.csr_re}, 32'h0);
        chk("mid_rst_we", {31'h0, bus.csr_we}, 32'h0);
        exp_perf = 0;
        @(negedge clk);
        resetn = 1'b0;
        we_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.csr_we || bus.csr_re || busy || done) we_n++;
        end
        chk("post_rst_quiet", we_n, 0);

        run("rw_after", 3'b001, 12'h300, 32'h00001888, 5'd1, 5'd5, 32'h00000008, 3, 1, 1, 32'h00001888, 1, 32'h00000008, 1'b0);
        run("ill_after",3'b100, 12'h300, 32'h00000001, 5'd1, 5'd5, 32'h00000008, 1, 0, 0, 32'h00000000, 0, 32'h00000000, 1'b1);

`ifdef CSR_ACCESS_PERF_EN
        @(negedge clk);
        chk("perf_after_reset", perf_count, exp_perf);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
